// File: rtl/dac_wave_gen.sv
// dac_wave_gen: sample source for an 8-bit IIC DAC writer.
// Produces DC, sawtooth, triangle or square codes at SYS_CLK/SAMPLE_RATE and
// offers each one over a valid/ready handshake. A sample that comes due
// while the previous one is still waiting is dropped and flagged.
//
// Ports:
//   wave_clk, wave_rst   system clock, asynchronous active-high reset
//   wave_en              enable for the sample-rate tick
//   wave_mode[1:0]       0 DC, 1 sawtooth, 2 triangle, 3 square
//   wave_step[7:0]       phase increment per sample
//   wave_level[7:0]      DC level / square high level
//   dac_data[7:0]        code offered to the DAC writer (registered)
//   dac_valid            dac_data is valid (registered)
//   dac_ready            writer accepts a code this cycle
//   wave_overrun         one-cycle pulse when a sample is dropped (registered)
module dac_wave_gen #(
  parameter logic [27:0] SYS_CLK     = 28'd50_000_000,
  parameter logic [27:0] SAMPLE_RATE = 28'd1_000
) (
  input  logic       wave_clk,
  input  logic       wave_rst,
  input  logic       wave_en,
  input  logic [1:0] wave_mode,
  input  logic [7:0] wave_step,
  input  logic [7:0] wave_level,
  output logic [7:0] dac_data,
  output logic       dac_valid,
  input  logic       dac_ready,
  output logic       wave_overrun
);

  localparam int unsigned TICK_DIV = (SAMPLE_RATE == 28'd0) ? 32'd0
                                   : 32'(SYS_CLK / SAMPLE_RATE);
  localparam int unsigned CNT_W    = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_div_check
    $error("dac_wave_gen: SYS_CLK/SAMPLE_RATE must be at least 2");
  end

  typedef enum logic [1:0] {
    MODE_DC  = 2'd0,
    MODE_SAW = 2'd1,
    MODE_TRI = 2'd2,
    MODE_SQR = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       phase_q, phase_d;
  logic             dir_q, dir_d;      // 0 = up, 1 = down (triangle only)
  mode_e            mode_q;
  state_e           state_q;

  logic             tick_c;
  logic             mode_chg_c;
  logic [8:0]       sum9_c;
  logic [7:0]       code_c;

  assign tick_c     = wave_en && (cnt_q == TICK_MAX);
  assign mode_chg_c = (wave_mode != mode_q);
  assign sum9_c     = {1'b0, phase_q} + {1'b0, wave_step};

  // Sample-rate divider; parked at zero while disabled.
  always_ff @(posedge wave_clk or posedge wave_rst) begin
    if (wave_rst) begin
      cnt_q <= '0;
    end else if (!wave_en || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Current code and next phase/direction; a mode change overrides any tick.
  always_comb begin
    code_c  = phase_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    case (mode_q)
      MODE_DC: begin
        code_c = wave_level;
      end
      MODE_SAW: begin
        if (tick_c) phase_d = sum9_c[7:0];
      end
      MODE_TRI: begin
        if (tick_c) begin
          if (!dir_q) begin
            if (sum9_c > 9'd255) begin
              phase_d = 8'hFF;
              dir_d   = 1'b1;
            end else begin
              phase_d = sum9_c[7:0];
            end
          end else begin
            if ({1'b0, phase_q} < {1'b0, wave_step}) begin
              phase_d = 8'h00;
              dir_d   = 1'b0;
            end else begin
              phase_d = phase_q - wave_step;
            end
          end
        end
      end
      MODE_SQR: begin
        code_c = phase_q[7] ? wave_level : 8'h00;
        if (tick_c) phase_d = sum9_c[7:0];
      end
      default: ;
    endcase
    if (mode_chg_c) begin
      phase_d = 8'h00;
      dir_d   = 1'b0;
    end
  end

  // Waveform state registers.
  always_ff @(posedge wave_clk or posedge wave_rst) begin
    if (wave_rst) begin
      phase_q <= 8'h00;
      dir_q   <= 1'b0;
      mode_q  <= MODE_DC;
    end else begin
      phase_q <= phase_d;
      dir_q   <= dir_d;
      mode_q  <= mode_e'(wave_mode);
    end
  end

  // Handshake FSM: hold a code until accepted; a tick while blocked drops
  // the new sample, while a tick on the accepting cycle reloads without a bubble.
  always_ff @(posedge wave_clk or posedge wave_rst) begin
    if (wave_rst) begin
      state_q      <= S_IDLE;
      dac_data     <= 8'h00;
      dac_valid    <= 1'b0;
      wave_overrun <= 1'b0;
    end else begin
      wave_overrun <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick_c) begin
            dac_data  <= code_c;
            dac_valid <= 1'b1;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (dac_ready) begin
            if (tick_c) begin
              dac_data <= code_c;
            end else begin
              dac_valid <= 1'b0;
              state_q   <= S_IDLE;
            end
          end else if (tick_c) begin
            wave_overrun <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Testbench for dac_wave_gen with TICK_DIV = 10.
module tb_dac_wave_gen;

  logic       wave_clk;
  logic       wave_rst;
  logic       wave_en;
  logic [1:0] wave_mode;
  logic [7:0] wave_step;
  logic [7:0] wave_level;
  logic [7:0] dac_data;
  logic       dac_valid;
  logic       dac_ready;
  logic       wave_overrun;

  dac_wave_gen #(
    .SYS_CLK     (28'd100),
    .SAMPLE_RATE (28'd10)
  ) dut (
    .wave_clk     (wave_clk),
    .wave_rst     (wave_rst),
    .wave_en      (wave_en),
    .wave_mode    (wave_mode),
    .wave_step    (wave_step),
    .wave_level   (wave_level),
    .dac_data     (dac_data),
    .dac_valid    (dac_valid),
    .dac_ready    (dac_ready),
    .wave_overrun (wave_overrun)
  );

  initial wave_clk = 1'b0;
  always #5 wave_clk = ~wave_clk;

  typedef struct packed {
    logic [1:0]      mode;
    logic [7:0]      step;
    logic [7:0]      level;
    logic [3:0]      n;
    logic [7:0][7:0] codes;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  int         checks;
  int         errors;
  int         cyc;
  int         ovr_cnt;
  int         ovr_cycle [$];
  logic [7:0] acc [$];

  always @(posedge wave_clk) cyc++;

  // Accepted codes and overrun pulses, sampled mid-cycle.
  always @(negedge wave_clk) begin
    if (!wave_rst) begin
      if (dac_valid && dac_ready) acc.push_back(dac_data);
      if (wave_overrun) begin
        ovr_cnt++;
        ovr_cycle.push_back(cyc);
      end
    end
  end

  function automatic logic [7:0][7:0] pk(input logic [7:0] a0, a1, a2, a3,
                                         a4, a5, a6, a7);
    pk = {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [7:0] s,
                          input logic [7:0] l);
    @(posedge wave_clk); #1;
    wave_rst   = 1'b1;
    wave_en    = 1'b0;
    dac_ready  = 1'b0;
    wave_mode  = m;
    wave_step  = s;
    wave_level = l;
    repeat (3) @(posedge wave_clk);
    #1 wave_rst = 1'b0;
    acc.delete();
    ovr_cycle.delete();
    ovr_cnt = 0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wave_clk);
      if (dac_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int acc_at(input int i);
    return (i < acc.size()) ? int'(acc[i]) : -1;
  endfunction

  initial begin
    int bad_v, bad_d, early;
    bit ok;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    ovr_cnt   = 0;
    wave_rst  = 1'b1;
    wave_en   = 1'b0;
    wave_mode = 2'd0;
    wave_step = 8'd0;
    wave_level = 8'd0;
    dac_ready = 1'b0;

    vecs[0] = '{mode: 2'd1, step: 8'd64,  level: 8'h00, n: 4'd6,
                codes: pk(8'd0, 8'd64, 8'd128, 8'd192, 8'd0, 8'd64, 8'd0, 8'd0)};
    vecs[1] = '{mode: 2'd2, step: 8'd100, level: 8'h00, n: 4'd8,
                codes: pk(8'd0, 8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100)};
    vecs[2] = '{mode: 2'd3, step: 8'd64,  level: 8'hA5, n: 4'd5,
                codes: pk(8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'd0, 8'd0, 8'd0)};
    vecs[3] = '{mode: 2'd0, step: 8'd17,  level: 8'h3C, n: 4'd4,
                codes: pk(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'd0, 8'd0, 8'd0, 8'd0)};
    vecs[4] = '{mode: 2'd1, step: 8'd200, level: 8'h00, n: 4'd6,
                codes: pk(8'd0, 8'd200, 8'd144, 8'd88, 8'd32, 8'd232, 8'd0, 8'd0)};
    vecs[5] = '{mode: 2'd2, step: 8'd255, level: 8'h00, n: 4'd6,
                codes: pk(8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0)};
    vecs[6] = '{mode: 2'd1, step: 8'd0,   level: 8'h00, n: 4'd3,
                codes: pk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0)};
    vecs[7] = '{mode: 2'd3, step: 8'd128, level: 8'h5A, n: 4'd4,
                codes: pk(8'h00, 8'h5A, 8'h00, 8'h5A, 8'd0, 8'd0, 8'd0, 8'd0)};
    vecs[8] = '{mode: 2'd3, step: 8'd0,   level: 8'hFF, n: 4'd3,
                codes: pk(8'h00, 8'h00, 8'h00, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0)};

    // Reset values while reset is held, then idle with the generator off.
    #12;
    chk("rst_valid", int'(dac_valid), 0);
    chk("rst_data", int'(dac_data), 0);
    chk("rst_overrun", int'(wave_overrun), 0);
    do_reset(2'd1, 8'd64, 8'h00);
    bad_v = 0;
    bad_d = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge wave_clk);
      if (dac_valid) bad_v++;
      if (dac_data != 8'h00) bad_d++;
    end
    chk("idle_valid_cycles", bad_v, 0);
    chk("idle_data_cycles", bad_d, 0);
    chk("idle_overruns", ovr_cnt, 0);

    // First-sample latency: valid appears on the 11th negedge after enable.
    do_reset(2'd1, 8'd64, 8'h00);
    @(posedge wave_clk); #1;
    wave_en   = 1'b1;
    dac_ready = 1'b1;
    early = 0;
    repeat (10) begin
      @(negedge wave_clk);
      if (dac_valid) early++;
    end
    chk("lat_early_valid", early, 0);
    @(negedge wave_clk);
    chk("lat_valid", int'(dac_valid), 1);
    chk("lat_data", int'(dac_data), 0);
    @(negedge wave_clk);
    chk("lat_valid_drop", int'(dac_valid), 0);

    // Table of free-running sequences with the writer always ready.
    for (int v = 0; v < NVEC; v++) begin
      do_reset(vecs[v].mode, vecs[v].step, vecs[v].level);
      @(posedge wave_clk); #1;
      wave_en   = 1'b1;
      dac_ready = 1'b1;
      repeat (int'(vecs[v].n) * 10 + 5) @(posedge wave_clk);
      #1;
      for (int i = 0; i < int'(vecs[v].n); i++)
        chk($sformatf("vec%0d_code%0d", v, i), acc_at(i), int'(vecs[v].codes[i]));
      chk($sformatf("vec%0d_overruns", v), ovr_cnt, 0);
    end

    // Blocked writer: held code stays, two drops 10 cycles apart, then code 3.
    do_reset(2'd1, 8'd1, 8'h00);
    @(posedge wave_clk); #1;
    wave_en = 1'b1;
    wait_valid(40, ok);
    chk("blk_first_valid", int'(ok), 1);
    bad_d = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge wave_clk);
      if (dac_data != 8'h00 || !dac_valid) bad_d++;
    end
    chk("blk_hold_stable", bad_d, 0);
    chk("blk_overruns", ovr_cnt, 2);
    chk("blk_overrun_gap",
        (ovr_cycle.size() >= 2) ? ovr_cycle[1] - ovr_cycle[0] : -1, 10);
    @(posedge wave_clk); #1;
    acc.delete();
    dac_ready = 1'b1;
    repeat (10) @(posedge wave_clk);
    #1;
    chk("blk_accept_held", acc_at(0), 0);
    chk("blk_accept_next", acc_at(1), 3);
    chk("blk_accept_count", acc.size(), 2);

    // Mode switch between ticks: triangle restarts from 0.
    do_reset(2'd1, 8'd64, 8'h00);
    @(posedge wave_clk); #1;
    wave_en   = 1'b1;
    dac_ready = 1'b1;
    repeat (25) @(posedge wave_clk);
    #1 wave_mode = 2'd2;
    repeat (30) @(posedge wave_clk);
    #1;
    chk("sw_code0", acc_at(0), 0);
    chk("sw_code1", acc_at(1), 64);
    chk("sw_code2", acc_at(2), 0);
    chk("sw_code3", acc_at(3), 64);
    chk("sw_code4", acc_at(4), 128);

    // Mode switch on the tick cycle: old phase emitted, then restart.
    do_reset(2'd1, 8'd64, 8'h00);
    @(posedge wave_clk); #1;
    wave_en   = 1'b1;
    dac_ready = 1'b1;
    repeat (19) @(posedge wave_clk);
    #1 wave_mode = 2'd2;
    repeat (25) @(posedge wave_clk);
    #1;
    chk("swt_code0", acc_at(0), 0);
    chk("swt_code1", acc_at(1), 64);
    chk("swt_code2", acc_at(2), 0);
    chk("swt_code3", acc_at(3), 64);

    // Reset while a code is held: outputs clear at once, phase restarts.
    do_reset(2'd1, 8'd64, 8'h00);
    @(posedge wave_clk); #1;
    wave_en   = 1'b1;
    dac_ready = 1'b1;
    repeat (15) @(posedge wave_clk);
    #1 dac_ready = 1'b0;
    wait_valid(30, ok);
    chk("hrst_hold_valid", int'(ok), 1);
    chk("hrst_hold_data", int'(dac_data), 64);
    #2 wave_rst = 1'b1;
    #1;
    chk("hrst_async_valid", int'(dac_valid), 0);
    chk("hrst_async_data", int'(dac_data), 0);
    @(posedge wave_clk); #1;
    wave_rst  = 1'b0;
    dac_ready = 1'b1;
    acc.delete();
    repeat (25) @(posedge wave_clk);
    #1;
    chk("hrst_code0", acc_at(0), 0);
    chk("hrst_code1", acc_at(1), 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_wave_gen.md
Name: dac_wave_gen

Overview:
- Upstream sample source for the IIC DAC writer (PCF8591-class, 8-bit code).
- Generates DC, sawtooth, triangle or square codes at a fixed sample rate derived from the system clock.
- Presents each code to the DAC writer over a valid/ready handshake.
- Reports samples dropped because the writer was still busy.

Parameters:
- SYS_CLK, 28'd50_000_000, system clock frequency in Hz.
- SAMPLE_RATE, 28'd1_000, samples per second. TICK_DIV = SYS_CLK/SAMPLE_RATE must be >= 2; elaboration error otherwise.

Ports:
- wave_clk  input  1  system clock.
- wave_rst  input  1  asynchronous, active-high reset.
- wave_en  input  1  generator enable.
- wave_mode  input  2  0 = DC, 1 = sawtooth, 2 = triangle, 3 = square.
- wave_step  input  8  phase increment per sample.
- wave_level  input  8  DC output level; square-wave high level.
- dac_data  output  8  code presented to the DAC writer.
- dac_valid  output  1  dac_data is valid.
- dac_ready  input  1  DAC writer can accept a code this cycle.
- wave_overrun  output  1  one-cycle pulse when a sample is dropped.

Behaviour:
- Reset (async, wave_rst = 1) sets all of the following to 0: tick counter, phase, dir (0 = up), mode_q, FSM state (IDLE), dac_data, dac_valid, wave_overrun.
- Tick counter: counts 0..TICK_DIV-1 while wave_en = 1. tick = 1 for the single cycle in which count == TICK_DIV-1; the count then wraps to 0. When wave_en = 0 the count is held at 0 and no ticks occur.
- First tick arrives TICK_DIV cycles after wave_en rises.
- Sample code is computed from the current state; the update is applied on the tick:
  - DC: code = wave_level; phase unchanged.
  - Sawtooth: code = phase; phase <= phase + wave_step, mod 256.
  - Square: code = phase[7] ? wave_level : 0; phase <= phase + wave_step, mod 256.
  - Triangle: code = phase.
    - dir up: if phase + step > 255, phase <= 255 and dir <= down; else phase <= phase + step.
    - dir down: if phase < step, phase <= 0 and dir <= up; else phase <= phase - step.
    - Use 9-bit arithmetic for these comparisons.
- wave_step = 0 produces a constant code in every mode.
- Mode change: mode_q registers wave_mode. On any cycle where wave_mode != mode_q, phase <= 0 and dir <= up.
  - This reset has priority over a tick update in the same cycle; the code emitted on that tick uses the old phase.
- wave_step and wave_level are sampled only at the tick.
- FSM, states IDLE and HOLD:
  - IDLE + tick: dac_data <= code, dac_valid <= 1, go to HOLD. Latency is 1 cycle from tick to valid.
  - HOLD: dac_data and dac_valid remain stable until a cycle with dac_ready = 1.
  - HOLD + dac_ready, no tick: dac_valid <= 0, go to IDLE.
  - HOLD + dac_ready + tick in the same cycle: load the new code, keep dac_valid = 1, stay in HOLD. There is no bubble.
  - HOLD + tick, no dac_ready: the new sample is discarded. dac_data is unchanged, wave_overrun = 1 for the next cycle only. phase/dir still advance, so timing is preserved.
- Clearing wave_en stops new ticks. A transfer already pending in HOLD still completes normally. phase and dir hold their values.
- dac_ready is ignored in IDLE.
- Assertion of wave_rst at any time, including mid-transfer, forces the reset values immediately.

Test Plan:
All scenarios use SYS_CLK = 100 and SAMPLE_RATE = 10, so TICK_DIV = 10.
1. Reset then release, wave_en = 0 for 50 cycles -> dac_valid = 0, dac_data = 0, wave_overrun never asserted.
2. Sawtooth, step = 64, dac_ready = 1 always, wave_en raised at cycle 0:
   - Tick occurs at cycle 9; dac_valid rises at cycle 10.
   - Accepted codes are 0, 64, 128, 192, 0, ..., with one transfer every 10 cycles.
3. Triangle, step = 100, dac_ready = 1 -> codes 0, 100, 200, 255, 155, 55, 0, 100.
4. Square, level = 0xA5, step = 64 -> codes 0, 0, 0xA5, 0xA5, 0. DC mode with level = 0x3C -> every code is 0x3C.
5. Sawtooth, step = 1, dac_ready held 0 for 25 cycles after the first valid:
   - dac_data stays 0 throughout.
   - wave_overrun pulses twice, 10 cycles apart.
   - After dac_ready rises, the next accepted code is 3.
6. Mode switch from sawtooth to triangle mid-run, and wave_rst asserted while in HOLD:
   - After the switch the sequence restarts from 0.
   - On reset, dac_valid drops asynchronously and phase = 0.
